// File: rtl/lsu_store_ctrl.sv
// LSU store sequencer: store FIFO, req/ack memory-port driver, byte-lane enables and misalignment checks.
// Build macro STORE_MISALIGN_SPLIT_EN: misaligned half/word stores are split into two word accesses instead of dropped.
module lsu_store_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        write_enable,
  input  logic              mem_ack,
  output logic              st_err,
  output logic [ADDR_W-1:0] err_addr,
  output logic              busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
`ifdef STORE_MISALIGN_SPLIT_EN
  localparam logic [1:0] ST_ISSUE2 = 2'd2;
`endif

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // ---------------- store FIFO ----------------
  logic [1:0]        fifo_size [DEPTH];
  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [31:0]       fifo_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              full, empty, push, load;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign st_ready = !full;
  assign push     = st_valid && !full;

  // NOTE: the entry array is deliberately not reset; only pointers and count need a known value, and no entry is read before it is written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_size[wr_ptr_q] <= st_size;
      fifo_addr[wr_ptr_q] <= st_addr;
      fifo_data[wr_ptr_q] <= st_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (load) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, load})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------- head decode ----------------
  logic [1:0]        head_size;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_data;
  logic [1:0]        head_off;
  logic [3:0]        lane_mask, lane_we;
  logic [31:0]       lane_wdata;
  logic              misaligned, illegal, drop;

  assign head_size = fifo_size[rd_ptr_q];
  assign head_addr = fifo_addr[rd_ptr_q];
  assign head_data = fifo_data[rd_ptr_q];
  assign head_off  = head_addr[1:0];

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path through the case can infer a latch.
    lane_mask  = 4'b0000;
    lane_wdata = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (head_size)
      SZ_BYTE: begin
        lane_mask  = 4'b0001;
        lane_wdata = {4{head_data[7:0]}};
      end
      SZ_HALF: begin
        lane_mask  = 4'b0011;
        lane_wdata = {2{head_data[15:0]}};
        misaligned = head_off[0];
      end
      SZ_WORD: begin
        lane_mask  = 4'b1111;
        lane_wdata = head_data;
        misaligned = (head_off != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    lane_we = lane_mask << head_off;
  end

`ifdef STORE_MISALIGN_SPLIT_EN
  // Misaligned data/mask shifted across a 64-bit window: low word goes first, high word to addr+4.
  logic [31:0] masked_data;
  logic [63:0] wide_data;
  logic [7:0]  wide_we;

  assign masked_data = (head_size == SZ_HALF) ? {16'h0000, head_data[15:0]} : head_data;
  assign wide_data   = {32'h0, masked_data} << {head_off, 3'b000};
  assign wide_we     = {4'h0, lane_mask} << head_off;
  assign drop        = illegal;
`else
  assign drop        = illegal || misaligned;
`endif

  // ---------------- issue FSM and holding register ----------------
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic              xfer_last;
`ifdef STORE_MISALIGN_SPLIT_EN
  logic              split_q, split_d;
  logic [31:0]       wdata_hi_q, wdata_hi_d;
  logic [3:0]        we_hi_q, we_hi_d;

  assign xfer_last = mem_ack && ((state_q == ST_ISSUE && !split_q) || state_q == ST_ISSUE2);
`else
  assign xfer_last = mem_ack && (state_q == ST_ISSUE);
`endif

  // The head is taken whenever the port is free or its final access is acknowledged this edge.
  assign load = !empty && (state_q == ST_IDLE || xfer_last);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;
`ifdef STORE_MISALIGN_SPLIT_EN
    split_d    = split_q;
    wdata_hi_d = wdata_hi_q;
    we_hi_d    = we_hi_q;
`endif
    if (load) begin
      if (drop) begin
        state_d    = ST_IDLE;
        err_d      = 1'b1;
        err_addr_d = head_addr;
      end else begin
        state_d = ST_ISSUE;
        addr_d  = {head_addr[ADDR_W-1:2], 2'b00};
`ifdef STORE_MISALIGN_SPLIT_EN
        split_d    = misaligned;
        wdata_d    = misaligned ? wide_data[31:0] : lane_wdata;
        we_d       = misaligned ? wide_we[3:0]    : lane_we;
        wdata_hi_d = wide_data[63:32];
        we_hi_d    = wide_we[7:4];
`else
        wdata_d = lane_wdata;
        we_d    = lane_we;
`endif
      end
    end else if (mem_ack) begin
`ifdef STORE_MISALIGN_SPLIT_EN
      if (state_q == ST_ISSUE)       state_d = split_q ? ST_ISSUE2 : ST_IDLE;
      else if (state_q == ST_ISSUE2) state_d = ST_IDLE;
`else
      if (state_q == ST_ISSUE) state_d = ST_IDLE;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
`ifdef STORE_MISALIGN_SPLIT_EN
      split_q    <= 1'b0;
      wdata_hi_q <= '0;
      we_hi_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
`ifdef STORE_MISALIGN_SPLIT_EN
      split_q    <= split_d;
      wdata_hi_q <= wdata_hi_d;
      we_hi_q    <= we_hi_d;
`endif
    end
  end

  // ---------------- outputs ----------------
  assign mem_req = (state_q != ST_IDLE);
`ifdef STORE_MISALIGN_SPLIT_EN
  assign mem_addr     = !mem_req ? '0 : (state_q == ST_ISSUE2) ? addr_q + ADDR_W'(4) : addr_q;
  assign mem_wdata    = !mem_req ? '0 : (state_q == ST_ISSUE2) ? wdata_hi_q : wdata_q;
  assign write_enable = !mem_req ? '0 : (state_q == ST_ISSUE2) ? we_hi_q : we_q;
`else
  assign mem_addr     = mem_req ? addr_q  : '0;
  assign mem_wdata    = mem_req ? wdata_q : '0;
  assign write_enable = mem_req ? we_q    : '0;
`endif
  assign st_err   = err_q;
  assign err_addr = err_addr_q;
  assign busy     = !empty || mem_req;

endmodule

// File: tb/tb_lsu_store_ctrl.sv
// Directed bench for lsu_store_ctrl: reset, lane generation, ack stalls, back-to-back, misaligned and illegal stores.
module tb_lsu_store_ctrl;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              st_valid;
  logic              st_ready;
  logic [1:0]        st_size;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        write_enable;
  logic              mem_ack;
  logic              st_err;
  logic [ADDR_W-1:0] err_addr;
  logic              busy;

  int total = 0;
  int bad   = 0;

  lsu_store_ctrl #(.DEPTH(4), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .write_enable(write_enable),
    .mem_ack(mem_ack), .st_err(st_err), .err_addr(err_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    st_valid = v;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ack = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    #3;
    total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL reset_st_ready: got %b want 1", st_ready); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (st_err !== 1'b0) begin bad++; $display("FAIL reset_st_err: got %b want 0", st_err); end
    total++; if ({mem_addr, mem_wdata, write_enable, err_addr} !== '0) begin
      bad++; $display("FAIL reset_buses: addr %h wdata %h we %b err_addr %h want all 0", mem_addr, mem_wdata, write_enable, err_addr);
    end
    step(); step();
    rst = 1'b0;
    step();
    total++; if (mem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle: req %b busy %b want 0 0", mem_req, busy); end
  endtask

  task automatic test_byte();
    mem_ack = 1'b1;
    drive(1'b1, 2'b00, 32'h0000_1001, 32'h0000_00A5);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    total++; if (mem_req !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL sb_latency: req %b busy %b want 0 1", mem_req, busy); end
    step();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL sb_req: got %b want 1", mem_req); end
    total++; if (mem_addr !== 32'h0000_1000) begin bad++; $display("FAIL sb_addr: got %h want 00001000", mem_addr); end
    total++; if (write_enable !== 4'b0010) begin bad++; $display("FAIL sb_we: got %b want 0010", write_enable); end
    total++; if (mem_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", mem_wdata); end
    step();
    total++; if (mem_req !== 1'b0 || write_enable !== 4'b0000 || mem_wdata !== 32'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL sb_done: req %b we %b wdata %h busy %b want 0 0000 0 0", mem_req, write_enable, mem_wdata, busy);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_half_wait();
    mem_ack = 1'b0;
    drive(1'b1, 2'b01, 32'h0000_1002, 32'h0000_1234);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1000 || write_enable !== 4'b1100 || mem_wdata !== 32'h1234_1234) begin
        bad++; $display("FAIL sh_hold cycle %0d: req %b addr %h we %b wdata %h want 1 00001000 1100 12341234",
                        i, mem_req, mem_addr, write_enable, mem_wdata);
      end
      if (i == 3) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL sh_release: req %b want 0", mem_req); end
  endtask

  task automatic test_back_to_back();
    mem_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 2'b10, 32'h0000_0100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      total++; if (st_ready !== (i < 5)) begin bad++; $display("FAIL fill_ready push %0d: got %b want %b", i, st_ready, (i < 5)); end
      step();
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", st_ready); end
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0100 + 32'(4 * i) || mem_wdata !== 32'hC0DE_0000 + 32'(i)
                   || write_enable !== 4'b1111) begin
        bad++; $display("FAIL b2b access %0d: req %b addr %h wdata %h we %b want 1 %h %h 1111",
                        i, mem_req, mem_addr, mem_wdata, write_enable, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      end
      step();
    end
    total++; if (mem_req !== 1'b0 || busy !== 1'b0 || st_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_drain: req %b busy %b ready %b want 0 0 1", mem_req, busy, st_ready);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_misaligned();
    mem_ack = 1'b1;
    drive(1'b1, 2'b10, 32'h0000_1006, 32'h1234_5678);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    step();
`ifdef STORE_MISALIGN_SPLIT_EN
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1004 || write_enable !== 4'b1100 || mem_wdata !== 32'h5678_0000) begin
      bad++; $display("FAIL split_lo: req %b addr %h we %b wdata %h want 1 00001004 1100 56780000", mem_req, mem_addr, write_enable, mem_wdata);
    end
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1008 || write_enable !== 4'b0011 || mem_wdata !== 32'h0000_1234) begin
      bad++; $display("FAIL split_hi: req %b addr %h we %b wdata %h want 1 00001008 0011 00001234", mem_req, mem_addr, write_enable, mem_wdata);
    end
    step();
    total++; if (mem_req !== 1'b0 || st_err !== 1'b0) begin bad++; $display("FAIL split_done: req %b err %b want 0 0", mem_req, st_err); end
`else
    total++; if (mem_req !== 1'b0 || st_err !== 1'b1 || err_addr !== 32'h0000_1006) begin
      bad++; $display("FAIL misalign_drop: req %b err %b err_addr %h want 0 1 00001006", mem_req, st_err, err_addr);
    end
    step();
    total++; if (mem_req !== 1'b0 || st_err !== 1'b0 || err_addr !== 32'h0000_1006 || busy !== 1'b0) begin
      bad++; $display("FAIL misalign_after: req %b err %b err_addr %h busy %b want 0 0 00001006 0", mem_req, st_err, err_addr, busy);
    end
`endif
    mem_ack = 1'b0;
  endtask

  task automatic test_illegal();
    logic [1:0]  sz_v   [3] = '{2'b10, 2'b11, 2'b10};
    logic [31:0] ad_v   [3] = '{32'h0000_3000, 32'h0000_2000, 32'h0000_3004};
    logic        req_x  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] addr_x [5] = '{32'h0, 32'h0000_3000, 32'h0, 32'h0000_3004, 32'h0};
    logic        err_x  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    mem_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(1'b1, sz_v[k], ad_v[k], 32'hD00D_0000 + 32'(k));
      else       drive(1'b0, 2'b00, 32'h0, 32'h0);
      step();
      total++; if (mem_req !== req_x[k] || mem_addr !== addr_x[k] || st_err !== err_x[k]) begin
        bad++; $display("FAIL illegal_seq cycle %0d: req %b addr %h err %b want %b %h %b",
                        k, mem_req, mem_addr, st_err, req_x[k], addr_x[k], err_x[k]);
      end
    end
    total++; if (err_addr !== 32'h0000_2000 || busy !== 1'b0) begin
      bad++; $display("FAIL illegal_err_addr: err_addr %h busy %b want 00002000 0", err_addr, busy);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_ack = 1'b0;
    drive(1'b1, 2'b10, 32'h0000_4000, 32'h1111_1111);
    step();
    drive(1'b1, 2'b10, 32'h0000_4004, 32'h2222_2222);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL midrst_pre: req %b want 1", mem_req); end
    #2 rst = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0 || st_err !== 1'b0 || busy !== 1'b0 || st_ready !== 1'b1 || err_addr !== 32'h0) begin
      bad++; $display("FAIL midrst_async: req %b err %b busy %b ready %b err_addr %h want 0 0 0 1 0",
                      mem_req, st_err, busy, st_ready, err_addr);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (mem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_quiet cycle %0d: req %b busy %b want 0 0", i, mem_req, busy); end
    end
    drive(1'b1, 2'b00, 32'h0000_5003, 32'h0000_007E);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_5000 || write_enable !== 4'b1000 || mem_wdata !== 32'h7E7E_7E7E) begin
      bad++; $display("FAIL midrst_new: req %b addr %h we %b wdata %h want 1 00005000 1000 7e7e7e7e", mem_req, mem_addr, write_enable, mem_wdata);
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    total++; if (mem_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_end: req %b busy %b want 0 0", mem_req, busy); end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half_wait();
    test_back_to_back();
    test_misaligned();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
